// File: rtl/fade_pkg.sv
// Shared types and reset-phase helper for the multi-channel fade generator.
package fade_pkg;

    typedef enum logic [1:0] {RISE, HOLD_HI, FALL, HOLD_LO} fade_state_t;

    typedef struct packed {
        fade_state_t state;
        logic [31:0] s;
        logic [31:0] level;
    } fade_phase_t;

    // Channels are spread evenly over one rise+fall period; plateaus are not counted.
    function automatic fade_phase_t reset_phase(int k, int channels, int steps, int inc);
        fade_phase_t r;
        int p;
        p = (k * 2 * steps) / channels;
        if (p < steps) begin
            r.state = RISE;
            r.s     = 32'(p);
            r.level = 32'(p * inc);
        end else begin
            r.state = FALL;
            r.s     = 32'(p - steps);
            r.level = 32'((2 * steps - p) * inc);
        end
        return r;
    endfunction

endpackage

// File: rtl/fade_channel.sv
// One fade channel: triangle FSM with optional plateaus, level register and
// registered PWM comparator. Advances only on step_tick; load restores reset phase.
module fade_channel
    import fade_pkg::*;
#(
    parameter int K          = 0,
    parameter int CHANNELS   = 1,
    parameter int STEPS      = 1,
    parameter int HOLD_STEPS = 0,
    parameter int INC_VAL    = 1,
    parameter int LW         = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_tick,
    input  logic          load,
    input  logic [LW-1:0] pwm_cnt,
    output logic [LW-1:0] level,
    output logic          pwm_out,
    output logic          ramp_done
);

    localparam int          SMAX = (STEPS > HOLD_STEPS) ? STEPS : HOLD_STEPS;
    localparam int          SW   = $clog2(SMAX + 1);
    localparam fade_phase_t PH   = reset_phase(K, CHANNELS, STEPS, INC_VAL);
    localparam logic [LW-1:0] LMAX  = LW'(STEPS * INC_VAL);
    localparam logic [LW-1:0] INC   = LW'(INC_VAL);
    localparam logic [LW-1:0] L0    = LW'(PH.level);
    localparam logic [SW-1:0] S0    = SW'(PH.s);
    localparam logic [SW-1:0] S_END = SW'(STEPS - 1);
    localparam logic [SW-1:0] H_END = SW'(HOLD_STEPS - 1);

    fade_state_t   state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [LW-1:0] level_q, level_d;
    logic          pwm_q, pwm_d;
    logic          done_q, done_d;
    logic [LW-1:0] level_up, level_dn;

    always_comb begin
        // Saturate at both bounds so a bad parameter set can never wrap.
        level_up = (level_q >= LMAX - INC) ? LMAX : level_q + INC;
        level_dn = (level_q <= INC) ? '0 : level_q - INC;

        state_d = state_q;
        s_d     = s_q;
        level_d = level_q;
        done_d  = 1'b0;
        pwm_d   = (pwm_cnt < level_q);

        if (load) begin
            state_d = PH.state;
            s_d     = S0;
            level_d = L0;
        end else if (step_tick) begin
            s_d = s_q + 1'b1;
            unique case (state_q)
                RISE: begin
                    level_d = level_up;
                    if (s_q == S_END) begin
                        s_d     = '0;
                        state_d = (HOLD_STEPS == 0) ? FALL : HOLD_HI;
                    end
                end
                HOLD_HI: if (s_q == H_END) begin
                    s_d     = '0;
                    state_d = FALL;
                end
                FALL: begin
                    level_d = level_dn;
                    if (s_q == S_END) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = (HOLD_STEPS == 0) ? RISE : HOLD_LO;
                    end
                end
                HOLD_LO: if (s_q == H_END) begin
                    s_d     = '0;
                    state_d = RISE;
                end
                default: state_d = RISE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PH.state;
            s_q     <= S0;
            level_q <= L0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            level_q <= level_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
        end
    end

    assign level     = level_q;
    assign pwm_out   = pwm_q;
    assign ramp_done = done_q;

endmodule

// File: rtl/multi_fade_pwm.sv
// Multi-channel triangle fade PWM: shared step prescaler and PWM counter feeding
// CHANNELS phase-offset fade_channel instances. MULTI_FADE_SYNC_EN adds a sync input.
module multi_fade_pwm
    import fade_pkg::*;
#(
    parameter  int CHANNELS      = 3,
    parameter  int PWM_INTERVAL  = 1200,
    parameter  int STEP_INTERVAL = 12000,
    parameter  int STEPS         = 200,
    parameter  int HOLD_STEPS    = 0,
    localparam int INC_VAL       = PWM_INTERVAL / STEPS,
    localparam int LW            = $clog2(PWM_INTERVAL + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
`ifdef MULTI_FADE_SYNC_EN
    input  logic                   sync,
`endif
    output logic [CHANNELS*LW-1:0] pwm_value,
    output logic [CHANNELS-1:0]    pwm_out,
    output logic [CHANNELS-1:0]    ramp_done
);

    localparam int PW = $clog2(STEP_INTERVAL + 1);

    if (STEPS < 1) begin : g_chk_steps
        $error("STEPS must be at least 1");
    end
    if (INC_VAL < 1) begin : g_chk_inc
        $error("PWM_INTERVAL/STEPS must be at least 1");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_chk_ch
        $error("CHANNELS must be in 1..8");
    end

    logic          sync_i;
    logic          step_tick;
    logic [PW-1:0] presc_q, presc_d;
    logic [LW-1:0] pwm_cnt_q, pwm_cnt_d;

`ifdef MULTI_FADE_SYNC_EN
    assign sync_i = sync;
`else
    assign sync_i = 1'b0;
`endif

    always_comb begin
        step_tick = en && (presc_q == PW'(STEP_INTERVAL - 1));
        presc_d   = presc_q;
        if (sync_i)  presc_d = '0;
        else if (en) presc_d = step_tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = (pwm_cnt_q == LW'(PWM_INTERVAL - 1)) ? '0 : pwm_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        fade_channel #(
            .K          (k),
            .CHANNELS   (CHANNELS),
            .STEPS      (STEPS),
            .HOLD_STEPS (HOLD_STEPS),
            .INC_VAL    (INC_VAL),
            .LW         (LW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .step_tick (step_tick),
            .load      (sync_i),
            .pwm_cnt   (pwm_cnt_q),
            .level     (pwm_value[k*LW +: LW]),
            .pwm_out   (pwm_out[k]),
            .ramp_done (ramp_done[k])
        );
    end

endmodule
